seq_frame_ctrl: RTL and testbench
=================================

Name: seq_frame_ctrl

Overview:
Frame-level scheduler for the Mono8 pixel pipeline: sequencer → crop/norm → hls4ml core.
- On each camera start-of-frame, issues ap_start handshakes to the sequentializer and the hls4ml core.
- Counts serialized pixel handshakes on the sequentializer output and waits for core completion.
- Maintains frame, drop and error status for the CustomLogic control registers.

Parameters:
IN_ROWS, 20, frame rows; must match sequentializer instance
IN_COLS, 20, frame columns; must match sequentializer instance
TIMEOUT_CYCLES, 65535, max cycles without progress in RUN/DRAIN before error
CNT_WIDTH, 16, width of frame_cnt / drop_cnt

Ports:
clk  in  1  pipeline clock
s_axis_resetn  in  1  asynchronous active-low reset
enable  in  1  level; software run enable
clear_err  in  1  pulse; clears sticky error
sof  in  1  single-cycle start-of-frame pulse from camera stream
seq_ap_start  out  1  ap_start to sequentializer
seq_ap_ready  in  1  sequentializer ap_ready
core_ap_start  out  1  ap_start to hls4ml core
core_ap_ready  in  1  core ap_ready
core_ap_done  in  1  core ap_done pulse
pix_valid  in  1  sequentializer m_axis_tvalid (monitor only)
pix_ready  in  1  sequentializer m_axis_tready (monitor only)
busy  out  1  high in any state other than IDLE
err  out  1  sticky timeout error
frame_cnt  out  CNT_WIDTH  completed frames
drop_cnt  out  CNT_WIDTH  sof pulses ignored
last_frame_cycles  out  32  cycles ARM→done of last frame (see Optional Feature)

Behaviour:
- Reset (asynchronous, s_axis_resetn=0): all outputs 0, state IDLE, internal counters 0.
- FRAME_PIXELS = IN_ROWS*IN_COLS. The pixel counter is $clog2(FRAME_PIXELS) wide and increments on pix_valid&&pix_ready.
- States: IDLE, ARM, RUN, DRAIN, ERR.
- IDLE: when sof&&enable → ARM on the next cycle. When sof&&!enable → ignored and not counted.
- ARM:
  - seq_ap_start and core_ap_start are asserted from the first ARM cycle.
  - Each start deasserts on the cycle after its own ap_ready is sampled high. The two acceptances are latched independently.
  - When both are latched (same cycle allowed) → RUN. The pixel counter is cleared on entry to RUN.
  - Pixel handshakes during ARM are counted.
- RUN: a handshake with count==FRAME_PIXELS-1 → DRAIN and the counter wraps to 0.
- DRAIN: core_ap_done=1 → frame_cnt+1 (wraps) → IDLE. A core_ap_done arriving during RUN is latched and consumed on DRAIN entry.
- Watchdog:
  - Counts cycles in ARM/RUN/DRAIN.
  - Resets on any pixel handshake, ap_ready acceptance or state change.
  - Reaching TIMEOUT_CYCLES → ERR.
- ERR: err=1 (sticky), both starts low, sof counted as drops. clear_err=1 → err=0 → IDLE.
- Drops: sof in ARM/RUN/DRAIN/ERR → drop_cnt+1, saturating at all-ones.
- Simultaneous sof and frame completion in DRAIN: the sof is counted as a drop; no back-to-back ARM.
- enable falling mid-frame: the current frame completes normally; no new frame starts.
- busy is combinational from state; all other outputs are registered.

Optional Feature:
Macro SEQ_FRAME_STATS_EN.
- Defined: a 32-bit cycle counter starts on ARM entry. On DRAIN→IDLE it is copied to last_frame_cycles, saturating at 0xFFFFFFFF. last_frame_cycles holds its value through ERR.
- Undefined: the counter is not built and last_frame_cycles is tied to 0.

Test Plan:
Use IN_ROWS=4, IN_COLS=8 (32 pixels), TIMEOUT_CYCLES=50.
- Nominal frame: enable=1, sof, both readies high on the second ARM cycle, 32 handshakes, core_ap_done 5 cycles later → frame_cnt=1, busy falls, drop_cnt=0.
- Staggered acceptance: seq_ap_ready at cycle 2, core_ap_ready at cycle 7 → seq_ap_start low after cycle 2, core_ap_start high until cycle 7, RUN entered at cycle 8.
- Drop counting: 3 sof pulses during RUN → drop_cnt=3, frame_cnt=1 after completion. A sof with enable=0 in IDLE → no change.
- Timeout: stall pix_ready after 10 pixels → err=1 after 50 idle cycles, starts low. clear_err → IDLE; the next frame completes → frame_cnt increments.
- Async reset mid-RUN: deassert s_axis_resetn at pixel 17 → all outputs 0 immediately, no clock required. After release a full frame completes with exactly 32 counted pixels.
- With SEQ_FRAME_STATS_EN defined, nominal frame with fixed timing → last_frame_cycles equals the bench-computed ARM-to-done count. Without the macro → reads 0.

Source files
------------

// File: rtl/seq_frame_ctrl.sv
// ============================================================================
// seq_frame_ctrl : frame scheduler for sequencer -> crop/norm -> hls4ml core
// Optional cycle statistics: SEQ_FRAME_STATS_EN     Revision: 1.0
// ============================================================================
`default_nettype none

module seq_frame_ctrl #(
  parameter int IN_ROWS        = 20,
  parameter int IN_COLS        = 20,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 s_axis_resetn,
  input  logic                 enable,
  input  logic                 clear_err,
  input  logic                 sof,
  output logic                 seq_ap_start,
  input  logic                 seq_ap_ready,
  output logic                 core_ap_start,
  input  logic                 core_ap_ready,
  input  logic                 core_ap_done,
  input  logic                 pix_valid,
  input  logic                 pix_ready,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [31:0]          last_frame_cycles
);

  localparam int FRAME_PIXELS = IN_ROWS * IN_COLS;
  localparam int PIX_W        = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;
  localparam int WD_W         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(FRAME_PIXELS - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    ERR   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [PIX_W-1:0]     pix_cnt_q, pix_cnt_d;
  logic [WD_W-1:0]      wd_q, wd_d;
  logic                 seq_start_q, seq_start_d;
  logic                 core_start_q, core_start_d;
  logic                 seq_acc_q, seq_acc_d;
  logic                 core_acc_q, core_acc_d;
  logic                 done_seen_q, done_seen_d;
  logic                 err_q, err_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  logic hs, seq_acc_now, core_acc_now, active;

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    wd_d         = wd_q;
    seq_start_d  = seq_start_q;
    core_start_d = core_start_q;
    seq_acc_d    = seq_acc_q;
    core_acc_d   = core_acc_q;
    done_seen_d  = done_seen_q;
    err_d        = err_q;
    frame_cnt_d  = frame_cnt_q;
    drop_cnt_d   = drop_cnt_q;

    hs           = pix_valid && pix_ready;
    seq_acc_now  = (state_q == ARM) && seq_start_q && seq_ap_ready;
    core_acc_now = (state_q == ARM) && core_start_q && core_ap_ready;
    active       = (state_q == ARM) || (state_q == RUN) || (state_q == DRAIN);

    if (hs) begin
      pix_cnt_d = (pix_cnt_q == PIX_LAST) ? '0 : pix_cnt_q + PIX_W'(1);
    end

    // Any sof outside IDLE is a dropped frame, including one coincident with completion
    if (sof && (state_q != IDLE) && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end

    case (state_q)
      IDLE: begin
        if (sof && enable) begin
          state_d      = ARM;
          seq_start_d  = 1'b1;
          core_start_d = 1'b1;
          seq_acc_d    = 1'b0;
          core_acc_d   = 1'b0;
          done_seen_d  = 1'b0;
        end
      end
      ARM: begin
        if (seq_acc_now) begin
          seq_start_d = 1'b0;
          seq_acc_d   = 1'b1;
        end
        if (core_acc_now) begin
          core_start_d = 1'b0;
          core_acc_d   = 1'b1;
        end
        if ((seq_acc_q || seq_acc_now) && (core_acc_q || core_acc_now)) begin
          state_d   = RUN;
          pix_cnt_d = '0;
        end
      end
      RUN: begin
        if (core_ap_done) begin
          done_seen_d = 1'b1;
        end
        if (hs && (pix_cnt_q == PIX_LAST)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (core_ap_done || done_seen_q) begin
          frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
          done_seen_d = 1'b0;
          state_d     = IDLE;
        end
      end
      ERR: begin
        if (clear_err) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog: only a cycle with no handshake, acceptance or state change counts
    if (!active) begin
      wd_d = '0;
    end else if (hs || seq_acc_now || core_acc_now || (state_d != state_q)) begin
      wd_d = '0;
    end else if (wd_q >= WD_LAST) begin
      wd_d         = '0;
      state_d      = ERR;
      err_d        = 1'b1;
      seq_start_d  = 1'b0;
      core_start_d = 1'b0;
      done_seen_d  = 1'b0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      state_q      <= IDLE;
      pix_cnt_q    <= '0;
      wd_q         <= '0;
      seq_start_q  <= 1'b0;
      core_start_q <= 1'b0;
      seq_acc_q    <= 1'b0;
      core_acc_q   <= 1'b0;
      done_seen_q  <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      wd_q         <= wd_d;
      seq_start_q  <= seq_start_d;
      core_start_q <= core_start_d;
      seq_acc_q    <= seq_acc_d;
      core_acc_q   <= core_acc_d;
      done_seen_q  <= done_seen_d;
      err_q        <= err_d;
      frame_cnt_q  <= frame_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

`ifdef SEQ_FRAME_STATS_EN
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] last_cycles_q, last_cycles_d;

  // cyc_q holds the cycles already spent in the frame; the completing cycle adds one
  always_comb begin
    cyc_d         = cyc_q;
    last_cycles_d = last_cycles_q;
    if ((state_q == IDLE) && (state_d == ARM)) begin
      cyc_d = '0;
    end else if (active && (cyc_q != '1)) begin
      cyc_d = cyc_q + 32'd1;
    end
    if ((state_q == DRAIN) && (state_d == IDLE)) begin
      last_cycles_d = (cyc_q == '1) ? '1 : cyc_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge s_axis_resetn) begin
    if (!s_axis_resetn) begin
      cyc_q         <= '0;
      last_cycles_q <= '0;
    end else begin
      cyc_q         <= cyc_d;
      last_cycles_q <= last_cycles_d;
    end
  end

  assign last_frame_cycles = last_cycles_q;
`else
  assign last_frame_cycles = 32'd0;
`endif

  assign busy          = (state_q != IDLE);
  assign err           = err_q;
  assign seq_ap_start  = seq_start_q;
  assign core_ap_start = core_start_q;
  assign frame_cnt     = frame_cnt_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_frame_ctrl.sv
// ============================================================================
// tb_seq_frame_ctrl : directed self-checking bench for seq_frame_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_frame_ctrl;

  localparam int IN_ROWS        = 4;
  localparam int IN_COLS        = 8;
  localparam int FRAME_PIXELS   = IN_ROWS * IN_COLS;
  localparam int TIMEOUT_CYCLES = 50;
  localparam int CNT_WIDTH      = 16;

  logic                 clk = 1'b0;
  logic                 s_axis_resetn;
  logic                 enable, clear_err, sof;
  logic                 seq_ap_start, seq_ap_ready;
  logic                 core_ap_start, core_ap_ready, core_ap_done;
  logic                 pix_valid, pix_ready;
  logic                 busy, err;
  logic [CNT_WIDTH-1:0] frame_cnt, drop_cnt;
  logic [31:0]          last_frame_cycles;

  int checks = 0;
  int errors = 0;

  seq_frame_ctrl #(
    .IN_ROWS       (IN_ROWS),
    .IN_COLS       (IN_COLS),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_WIDTH     (CNT_WIDTH)
  ) dut (
    .clk              (clk),
    .s_axis_resetn    (s_axis_resetn),
    .enable           (enable),
    .clear_err        (clear_err),
    .sof              (sof),
    .seq_ap_start     (seq_ap_start),
    .seq_ap_ready     (seq_ap_ready),
    .core_ap_start    (core_ap_start),
    .core_ap_ready    (core_ap_ready),
    .core_ap_done     (core_ap_done),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .busy             (busy),
    .err              (err),
    .frame_cnt        (frame_cnt),
    .drop_cnt         (drop_cnt),
    .last_frame_cycles(last_frame_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // sof, then both readies on the second ARM cycle; returns in the first RUN cycle
  task automatic start_frame();
    enable = 1'b1;
    sof = 1'b1;
    step();
    sof = 1'b0;
    step();
    seq_ap_ready  = 1'b1;
    core_ap_ready = 1'b1;
    step();
    seq_ap_ready  = 1'b0;
    core_ap_ready = 1'b0;
  endtask

  task automatic pixels(input int n);
    pix_valid = 1'b1;
    pix_ready = 1'b1;
    repeat (n) step();
    pix_valid = 1'b0;
    pix_ready = 1'b0;
  endtask

  task automatic pulse_done();
    core_ap_done = 1'b1;
    step();
    core_ap_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got 1 expected 0");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] exp_cycles;

    s_axis_resetn = 1'b0;
    enable = 1'b0; clear_err = 1'b0; sof = 1'b0;
    seq_ap_ready = 1'b0; core_ap_ready = 1'b0; core_ap_done = 1'b0;
    pix_valid = 1'b0; pix_ready = 1'b0;
    repeat (2) step();
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_seq_start", seq_ap_start, 0);
    check("rst_core_start", core_ap_start, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_last_cycles", last_frame_cycles, 0);
    s_axis_resetn = 1'b1;
    step();

    // Nominal frame: 2 ARM + 32 RUN + 5 DRAIN cycles
    enable = 1'b1;
    sof = 1'b1;
    step();
    sof = 1'b0;
    check("nom_arm_seq_start", seq_ap_start, 1);
    check("nom_arm_core_start", core_ap_start, 1);
    check("nom_arm_busy", busy, 1);
    step();
    seq_ap_ready = 1'b1; core_ap_ready = 1'b1;
    step();
    seq_ap_ready = 1'b0; core_ap_ready = 1'b0;
    check("nom_run_seq_start", seq_ap_start, 0);
    check("nom_run_core_start", core_ap_start, 0);
    pixels(FRAME_PIXELS);
    check("nom_drain_busy", busy, 1);
    check("nom_drain_frame_cnt", frame_cnt, 0);
    repeat (4) step();
    pulse_done();
    check("nom_frame_cnt", frame_cnt, 1);
    check("nom_busy_fall", busy, 0);
    check("nom_drop_cnt", drop_cnt, 0);
    exp_cycles = 32'(2 + FRAME_PIXELS + 5);
`ifdef SEQ_FRAME_STATS_EN
    check("nom_last_cycles", last_frame_cycles, exp_cycles);
`else
    check("nom_last_cycles", last_frame_cycles, 0);
`endif

    // sof with enable low in IDLE is ignored entirely
    enable = 1'b0;
    sof = 1'b1;
    step();
    sof = 1'b0;
    step();
    check("dis_busy", busy, 0);
    check("dis_drop_cnt", drop_cnt, 0);
    check("dis_frame_cnt", frame_cnt, 1);

    // Staggered acceptance: seq ready at ARM cycle 2, core ready at ARM cycle 7
    enable = 1'b1;
    sof = 1'b1;
    step();
    sof = 1'b0;
    step();
    seq_ap_ready = 1'b1;
    step();
    seq_ap_ready = 1'b0;
    check("stag_c3_seq_start", seq_ap_start, 0);
    check("stag_c3_core_start", core_ap_start, 1);
    pix_valid = 1'b1; pix_ready = 1'b1;
    repeat (4) step();
    check("stag_c7_core_start", core_ap_start, 1);
    core_ap_ready = 1'b1;
    step();
    core_ap_ready = 1'b0;
    check("stag_c8_core_start", core_ap_start, 0);
    pixels(FRAME_PIXELS);
    pulse_done();
    check("stag_frame_cnt", frame_cnt, 2);
    check("stag_busy", busy, 0);

    // Three sof pulses during RUN are dropped
    start_frame();
    pix_valid = 1'b1; pix_ready = 1'b1;
    repeat (5) step();
    sof = 1'b1; step(); sof = 1'b0;
    step();
    sof = 1'b1; step(); sof = 1'b0;
    repeat (3) step();
    sof = 1'b1; step(); sof = 1'b0;
    pixels(FRAME_PIXELS - 12);
    check("drop_cnt_run", drop_cnt, 3);
    check("drop_busy", busy, 1);
    pulse_done();
    check("drop_frame_cnt", frame_cnt, 3);
    check("drop_busy_fall", busy, 0);

    // Timeout: stall after 10 pixels
    start_frame();
    pixels(10);
    pix_valid = 1'b1;
    repeat (48) step();
    check("wd_err_early", err, 0);
    repeat (4) step();
    check("wd_err", err, 1);
    check("wd_busy", busy, 1);
    check("wd_seq_start", seq_ap_start, 0);
    check("wd_core_start", core_ap_start, 0);
    pix_valid = 1'b0;
    sof = 1'b1; step(); sof = 1'b0;
    check("err_drop_cnt", drop_cnt, 4);
    step();
    check("err_sticky", err, 1);
    clear_err = 1'b1; step(); clear_err = 1'b0;
    check("clr_err", err, 0);
    check("clr_busy", busy, 0);
    start_frame();
    pixels(FRAME_PIXELS);
    pulse_done();
    check("rec_frame_cnt", frame_cnt, 4);

    // Asynchronous reset in the middle of RUN, away from any clock edge
    start_frame();
    pixels(17);
    #2 s_axis_resetn = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_frame_cnt", frame_cnt, 0);
    check("arst_drop_cnt", drop_cnt, 0);
    check("arst_err", err, 0);
    check("arst_last_cycles", last_frame_cycles, 0);
    step();
    s_axis_resetn = 1'b1;
    step();

    // 31 pixels plus an early done must not complete; the 32nd pixel does
    start_frame();
    pixels(FRAME_PIXELS - 1);
    pulse_done();
    check("post_31_frame_cnt", frame_cnt, 0);
    check("post_31_busy", busy, 1);
    pixels(1);
    step();
    check("post_frame_cnt", frame_cnt, 1);
    check("post_busy", busy, 0);
    exp_cycles = 32'(2 + FRAME_PIXELS + 1 + 1);
`ifdef SEQ_FRAME_STATS_EN
    check("post_last_cycles", last_frame_cycles, exp_cycles);
`else
    check("post_last_cycles", last_frame_cycles, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
